// File: rtl/semafor_pkg.sv
// Shared encodings for the traffic-light lamp monitor: lamp codes, reported phases and FSM states.
package semafor_pkg;

  localparam int unsigned LAMP_W  = 3;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned CYC_W   = 16;

  localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;

  typedef enum logic [PHASE_W-1:0] {
    PH_UNK    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_UNK    = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_RED    = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Phase reported on phase_o for a given FSM state; FAULT reads as UNK.
  function automatic logic [PHASE_W-1:0] phase_of(input state_e s);
    logic [PHASE_W-1:0] p;
    p = PH_UNK;
    case (s)
      ST_GREEN:  p = PH_GREEN;
      ST_YELLOW: p = PH_YELLOW;
      ST_RED:    p = PH_RED;
      default:   p = PH_UNK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/semafor_phase_timer.sv
// Saturating tick counter for the current phase; len_on_exit includes a tick arriving in the exit cycle.
module semafor_phase_timer
  import semafor_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W:0]   len_on_exit
);

  localparam int unsigned LEN_W = CNT_W + 1;

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt         = cnt_q;
  assign len_on_exit = LEN_W'(cnt_q) + LEN_W'(tick_i);

endmodule

// File: rtl/semafor_monitor.sv
// Lamp-interface observer: decodes the controller's lamp code, checks phase order and
// phase lengths, raises sticky error flags and drives the pedestrian walk/countdown outputs.
module semafor_monitor
  import semafor_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_MIN    = 5,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned RED_TICKS    = 3,
  parameter int unsigned TOL          = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             rosu,
  input  logic             galben,
  input  logic             verde,
  input  logic             clr_i,
  output logic [1:0]       phase_o,
  output logic             ped_walk,
  output logic [CNT_W-1:0] ped_count,
  output logic             err_ill,
  output logic             err_ord,
  output logic             err_tim,
  output logic [15:0]      cycles
);

  localparam int unsigned LEN_W = CNT_W + 1;

  logic [LAMP_W-1:0] lamp;
  logic              lamp_ok;
  state_e            state_d, state_q;
  logic              state_chg;
  logic              skip_d, skip_q;
  logic [CNT_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_on_exit;
  int unsigned       len_u;
  logic              g_bad, y_bad, r_bad;
  logic              set_ill, set_ord, set_tim, cyc_inc;

  logic [PHASE_W-1:0] phase_d, phase_q;
  logic               walk_d, walk_q;
  logic [CNT_W-1:0]   pcnt_d, pcnt_q;
  logic               ill_d, ill_q, ord_d, ord_q, tim_d, tim_q;
  logic [CYC_W-1:0]   cycles_d, cycles_q;

  assign lamp    = {rosu, galben, verde};
  assign lamp_ok = (lamp == LAMP_G) || (lamp == LAMP_Y) || (lamp == LAMP_R);

  semafor_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick_i),
    .clr_i       (state_chg),
    .cnt         (cnt),
    .len_on_exit (len_on_exit)
  );

  // Phase-length windows evaluated on the length the old phase would have on exit.
  always_comb begin
    len_u = 32'(len_on_exit);
    g_bad = len_u < GREEN_MIN;
    y_bad = (len_u > YELLOW_TICKS + TOL) || (len_u + TOL < YELLOW_TICKS);
    r_bad = (len_u > RED_TICKS + TOL) || (len_u + TOL < RED_TICKS);
  end

  // Next-state and error detection; lamps are not looked at while in FAULT.
  always_comb begin
    state_d = state_q;
    set_ill = 1'b0;
    set_ord = 1'b0;
    set_tim = 1'b0;
    cyc_inc = 1'b0;
    if (state_q == ST_FAULT) begin
      if (clr_i) state_d = ST_UNK;
    end else if (!lamp_ok) begin
      state_d = ST_FAULT;
      set_ill = 1'b1;
    end else begin
      case (state_q)
        ST_UNK: begin
          if (lamp == LAMP_G)      state_d = ST_GREEN;
          else if (lamp == LAMP_Y) state_d = ST_YELLOW;
          else                     state_d = ST_RED;
        end
        ST_GREEN: begin
          if (lamp == LAMP_Y) begin
            state_d = ST_YELLOW;
            set_tim = !skip_q && g_bad;
          end else if (lamp == LAMP_R) begin
            state_d = ST_FAULT;
            set_ord = 1'b1;
          end
        end
        ST_YELLOW: begin
          if (lamp == LAMP_R) begin
            state_d = ST_RED;
            set_tim = !skip_q && y_bad;
          end else if (lamp == LAMP_G) begin
            state_d = ST_FAULT;
            set_ord = 1'b1;
          end
        end
        ST_RED: begin
          if (lamp == LAMP_G) begin
            state_d = ST_GREEN;
            set_tim = !skip_q && r_bad;
            cyc_inc = 1'b1;
          end else if (lamp == LAMP_Y) begin
            state_d = ST_FAULT;
            set_ord = 1'b1;
          end
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  // A phase entered from UNK has an unknown start, so its exit length is not judged.
  always_comb begin
    state_chg = (state_d != state_q);
    skip_d    = skip_q;
    if (state_chg) skip_d = (state_q == ST_UNK);
  end

  always_comb begin
    phase_d  = phase_of(state_d);
    walk_d   = (state_d == ST_RED);
    ill_d    = (ill_q & ~clr_i) | set_ill;
    ord_d    = (ord_q & ~clr_i) | set_ord;
    tim_d    = (tim_q & ~clr_i) | set_tim;
    cycles_d = cycles_q + CYC_W'(cyc_inc);
    pcnt_d   = '0;
    if ((state_q == ST_RED) && (state_d == ST_RED) && (cnt < CNT_W'(RED_TICKS))) begin
      pcnt_d = CNT_W'(RED_TICKS) - cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_UNK;
      skip_q   <= 1'b0;
      phase_q  <= '0;
      walk_q   <= 1'b0;
      pcnt_q   <= '0;
      ill_q    <= 1'b0;
      ord_q    <= 1'b0;
      tim_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      phase_q  <= phase_d;
      walk_q   <= walk_d;
      pcnt_q   <= pcnt_d;
      ill_q    <= ill_d;
      ord_q    <= ord_d;
      tim_q    <= tim_d;
      cycles_q <= cycles_d;
    end
  end

  assign phase_o   = phase_q;
  assign ped_walk  = walk_q;
  assign ped_count = pcnt_q;
  assign err_ill   = ill_q;
  assign err_ord   = ord_q;
  assign err_tim   = tim_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_semafor_monitor.sv
// Directed vector bench for semafor_monitor: one table of per-cycle expectations plus
// hand-written reset and cycles-wrap sequences.
module tb_semafor_monitor;

  logic        clk = 1'b0;
  logic        rst, tick_i, rosu, galben, verde, clr_i;
  logic [1:0]  phase_o;
  logic        ped_walk;
  logic [7:0]  ped_count;
  logic        err_ill, err_ord, err_tim;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  typedef struct {
    logic [2:0]  lamp;
    logic        tick;
    logic        clr;
    logic [1:0]  ph;
    logic        walk;
    logic [7:0]  pcnt;
    logic        ill;
    logic        ord;
    logic        tim;
    logic [15:0] cyc;
  } vec_t;

  vec_t vecs[$];

  semafor_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .tick_i    (tick_i),
    .rosu      (rosu),
    .galben    (galben),
    .verde     (verde),
    .clr_i     (clr_i),
    .phase_o   (phase_o),
    .ped_walk  (ped_walk),
    .ped_count (ped_count),
    .err_ill   (err_ill),
    .err_ord   (err_ord),
    .err_tim   (err_tim),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [2:0] l, input logic t, input logic c,
                     input logic [1:0] ph, input logic w, input logic [7:0] p,
                     input logic i, input logic o, input logic tm, input logic [15:0] cy);
    vec_t v;
    v.lamp = l; v.tick = t; v.clr = c; v.ph = ph; v.walk = w; v.pcnt = p;
    v.ill = i; v.ord = o; v.tim = tm; v.cyc = cy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] l, input logic t, input logic c);
    {rosu, galben, verde} = l;
    tick_i = t;
    clr_i  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ph, input logic w, input logic [7:0] p,
                         input logic i, input logic o, input logic tm, input logic [15:0] cy);
    chk({tag, ".phase"}, 32'(phase_o), 32'(ph));
    chk({tag, ".walk"}, 32'(ped_walk), 32'(w));
    chk({tag, ".pcnt"}, 32'(ped_count), 32'(p));
    chk({tag, ".ill"}, 32'(err_ill), 32'(i));
    chk({tag, ".ord"}, 32'(err_ord), 32'(o));
    chk({tag, ".tim"}, 32'(err_tim), 32'(tm));
    chk({tag, ".cyc"}, 32'(cycles), 32'(cy));
  endtask

  initial begin
    // Nominal loop; first green comes from UNK and is not length-checked.
    add(G,0,0, 1,0,0, 0,0,0, 0);
    for (int k = 0; k < 6; k++) add(G,1,0, 1,0,0, 0,0,0, 0);
    add(Y,0,0, 2,0,0, 0,0,0, 0);
    for (int k = 0; k < 2; k++) add(Y,1,0, 2,0,0, 0,0,0, 0);
    add(R,0,0, 3,1,0, 0,0,0, 0);
    add(R,1,0, 3,1,3, 0,0,0, 0);
    add(R,1,0, 3,1,2, 0,0,0, 0);
    add(R,1,0, 3,1,1, 0,0,0, 0);
    add(G,0,0, 1,0,0, 0,0,0, 1);
    for (int k = 0; k < 5; k++) add(G,1,0, 1,0,0, 0,0,0, 1);
    // Exit ticks count toward the old phase: green 6, yellow 1 (in tolerance).
    add(Y,1,0, 2,0,0, 0,0,0, 1);
    add(R,1,0, 3,1,0, 0,0,0, 1);
    // Countdown, then red stretched to 5 ticks.
    add(R,1,0, 3,1,3, 0,0,0, 1);
    add(R,1,0, 3,1,2, 0,0,0, 1);
    add(R,1,0, 3,1,1, 0,0,0, 1);
    add(R,1,0, 3,1,0, 0,0,0, 1);
    add(R,1,0, 3,1,0, 0,0,0, 1);
    add(G,0,0, 1,0,0, 0,0,1, 2);
    add(G,0,1, 1,0,0, 0,0,0, 2);
    // Short green (3), long yellow (4).
    for (int k = 0; k < 3; k++) add(G,1,0, 1,0,0, 0,0,0, 2);
    add(Y,0,0, 2,0,0, 0,0,1, 2);
    for (int k = 0; k < 4; k++) add(Y,1,0, 2,0,0, 0,0,1, 2);
    add(R,0,0, 3,1,0, 0,0,1, 2);
    add(R,0,0, 3,1,3, 0,0,1, 2);
    // Short red exit coincident with clr: set wins.
    add(G,0,1, 1,0,0, 0,0,1, 3);
    add(G,0,1, 1,0,0, 0,0,0, 3);
    // Wrong order, ignored inputs in FAULT, clear.
    add(R,0,0, 0,0,0, 0,1,0, 3);
    add(G,1,0, 0,0,0, 0,1,0, 3);
    add(Y,0,0, 0,0,0, 0,1,0, 3);
    add(R,0,0, 0,0,0, 0,1,0, 3);
    add(G,0,1, 0,0,0, 0,0,0, 3);
    add(G,0,0, 1,0,0, 0,0,0, 3);
    // Invalid codes.
    add(3'b110,0,0, 0,0,0, 1,0,0, 3);
    add(G,0,1, 0,0,0, 0,0,0, 3);
    add(3'b000,0,0, 0,0,0, 1,0,0, 3);
    add(G,0,1, 0,0,0, 0,0,0, 3);
    // Red->yellow and yellow->green order errors.
    add(R,0,0, 3,1,0, 0,0,0, 3);
    add(R,1,0, 3,1,3, 0,0,0, 3);
    add(Y,0,0, 0,0,0, 0,1,0, 3);
    add(3'b000,0,1, 0,0,0, 0,0,0, 3);
    add(G,0,0, 1,0,0, 0,0,0, 3);
    add(Y,0,0, 2,0,0, 0,0,0, 3);
    add(G,0,0, 0,0,0, 0,1,0, 3);
    add(G,0,1, 0,0,0, 0,0,0, 3);

    rst = 1'b1; {rosu, galben, verde} = G; tick_i = 1'b0; clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0,0,0, 0,0,0, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].lamp, vecs[i].tick, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].ph, vecs[i].walk, vecs[i].pcnt,
              vecs[i].ill, vecs[i].ord, vecs[i].tim, vecs[i].cyc);
    end

    // Reset in the middle of red.
    drive(R,0,0);
    drive(R,1,0);
    chk_all("pre_rst", 3,1,3, 0,0,0, 3);
    rst = 1'b1;
    drive(R,1,0);
    chk_all("mid_rst", 0,0,0, 0,0,0, 0);
    rst = 1'b0;

    // cycles wrap at 65535.
    drive(R,0,0);
    chk_all("wrap_red", 3,1,0, 0,0,0, 0);
    force dut.cycles_q = 16'hFFFF;
    drive(R,0,0);
    release dut.cycles_q;
    drive(R,0,0);
    chk("wrap_pre.cyc", 32'(cycles), 32'hFFFF);
    drive(G,0,0);
    chk_all("wrap", 1,0,0, 0,0,0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
